uart_rx_word: RTL and testbench
===============================

# uart_rx_word

Parametrised UART receiver that deserialises complete frames from the `rx` line and presents one parallel word per frame with parity and framing status. It supersedes the bit-level receiver in the UART path. It sits between the shared baud generator, which supplies `baud_tick` at OVERSAMPLE × baud rate, and the byte-consuming logic (command decoder, RSA operand loader). It adds configurable word length, parity, stop bits, majority-vote sampling, false-start rejection and error flags.

## Interface

- DATA_BITS, 8, data bits per frame (5..9), LSB first
- OVERSAMPLE, 16, baud_tick pulses per bit; even, ≥ 8
- PARITY_EN, 0, 1 = a parity bit follows the data bits
- PARITY_ODD, 0, parity sense when PARITY_EN = 1: 0 = even, 1 = odd
- STOP_BITS, 1, number of stop bits checked (1 or 2)

- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- baud_tick  in  1  one-clk pulse at OVERSAMPLE × baud rate
- rx  in  1  serial line, idle high, asynchronous to clk
- data_out  out  DATA_BITS  last received word; held until the next data_valid
- data_valid  out  1  one-clk pulse: a frame is complete
- parity_err  out  1  parity mismatch on the last frame; updated with data_valid
- frame_err  out  1  a stop bit sampled 0 on the last frame; updated with data_valid
- busy  out  1  high in every state except IDLE

## Operation

- `rx` passes through a 2-FF synchroniser. Both flops reset to 1. All logic below uses the synchronised value `rxs`.
- Define M = OVERSAMPLE/2. The tick counter `tc` has width clog2(OVERSAMPLE). It advances only on `baud_tick` and wraps OVERSAMPLE-1 → 0. A wrap marks a bit boundary.
- Each bit value is the majority of the `rxs` samples taken on the ticks where tc = M-1, M and M+1. The decision is made on the M+1 tick.
- States and transitions:
  - IDLE: tc held at 0. A falling edge of `rxs` (registered previous value 1, current 0) moves to START.
  - START: at the M+1 decision, majority 1 means a false start; return to IDLE with no output and no flag change. Majority 0 stays in START. On the tc wrap, go to DATA with bit index 0.
  - DATA: store each decided bit into the shift register at position `idx`, LSB first. On the wrap after bit DATA_BITS-1, go to PARITY if PARITY_EN = 1, otherwise to STOP.
  - PARITY: the decided bit is compared with the XOR of the data bits, inverted when PARITY_ODD = 1. A mismatch sets an internal parity flag. On the wrap, go to STOP.
  - STOP: each stop bit sampled 0 sets an internal frame flag. At the decision of the last stop bit, go to IDLE directly without waiting for the wrap. This gives half a bit of margin for the next start edge.
- At the last stop-bit decision, in one registered update:
  - data_out ← shift register
  - parity_err ← internal parity flag (0 when PARITY_EN = 0)
  - frame_err ← internal frame flag
  - data_valid ← 1 for exactly one clk
- Internal flags and the shift register clear on entry to START.
- A break condition (line held low) yields data_out = 0 with frame_err = 1. The FSM then stays in IDLE until `rxs` returns high and falls again.
- `rx` activity during STOP after the last decision has no effect on the completed frame.

## Timing

- Reset values: data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, busy = 0, state = IDLE, synchroniser = 1.
- Reset is asynchronous and may be asserted mid-frame. The partial frame is discarded and no data_valid is issued after release.
- Edge detection: START is entered 3 clk after `rx` falls (2 for the synchroniser, 1 for the edge register).
- data_valid rises on the clk edge following the `baud_tick` cycle of the last stop-bit decision.
- Frame length is F = 1 + DATA_BITS + PARITY_EN + STOP_BITS bits. Latency from the start-edge detect to data_valid is (F-1)·OVERSAMPLE + M + 2 baud_ticks, plus 1 clk.
- `baud_tick` asserted on consecutive clks is legal. Each asserted cycle counts as one tick.
- busy deasserts in the same cycle data_valid asserts.

## Test plan

- 8N1, OVERSAMPLE 16, send 0xA5 -> exactly one data_valid pulse with data_out = 0xA5, parity_err = 0, frame_err = 0, busy = 0 afterwards.
- Idle line, drive rx low for 5 baud_ticks then high -> no data_valid, busy returns to 0 before tick 9, flags unchanged.
- PARITY_EN = 1, PARITY_ODD = 0, send 0x3C with parity bit 1 -> data_out = 0x3C, parity_err = 1. Repeat with parity bit 0 -> parity_err = 0.
- Send 0x55 with the stop bit forced to 0 -> data_out = 0x55, frame_err = 1. Hold rx low afterwards for 3 frame times -> no further data_valid until rx goes high then low.
- DATA_BITS = 7, STOP_BITS = 2, send frames 0x41 and 0x7F back-to-back with no idle gap, plus a 1-tick low glitch at tc = M of one data bit -> two data_valid pulses, values 0x41 and 0x7F, no errors.
- Assert rst during data bit 4 of 0xFF, release, then send 0x12 -> outputs at reset values throughout; only one data_valid, data_out = 0x12.

Source files
------------

// File: rtl/uart_rx_word.sv
// Oversampling UART receiver: deserialises one frame per start edge into a
// parallel word, with majority-vote bit decisions and parity/framing status.
module uart_rx_word #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TC_LO   = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TC_MID  = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] TC_HI   = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
   localparam logic          PAR_ON    = (PARITY_EN != 0);
   localparam logic          PAR_INV   = (PARITY_ODD != 0);
   localparam logic          SIDX_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                 state, state_n;
   logic                   sync1, rxs, rx_prev;
   logic [TW-1:0]          tc, tc_n;
   logic [IW-1:0]          idx, idx_n;
   logic                   sidx, sidx_n;
   logic [DATA_BITS-1:0]   shift, shift_n;
   logic                   perr, perr_n, ferr, ferr_n;
   logic                   s_lo, s_mid;
   logic                   maj, decide, tick_wrap, done;

   // rx is asynchronous; rx_prev is the edge register behind the synchroniser
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b1;
         rxs     <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= rx;
         rxs     <= sync1;
         rx_prev <= rxs;
      end
   end

   assign decide    = baud_tick && (tc == TC_HI);
   assign tick_wrap = baud_tick && (tc == TC_LAST);
   assign maj       = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);
   assign busy      = (state != IDLE);

   always_comb begin
      state_n = state;
      tc_n    = tc;
      idx_n   = idx;
      sidx_n  = sidx;
      shift_n = shift;
      perr_n  = perr;
      ferr_n  = ferr;
      done    = 1'b0;
      if (state != IDLE && baud_tick)
         tc_n = (tc == TC_LAST) ? '0 : tc + 1'b1;
      case (state)
         IDLE: begin
            tc_n = '0;
            if (rx_prev && !rxs) begin
               state_n = START;
               idx_n   = '0;
               sidx_n  = 1'b0;
               shift_n = '0;
               perr_n  = 1'b0;
               ferr_n  = 1'b0;
            end
         end
         START: begin
            if (decide && maj) begin
               state_n = IDLE;
               tc_n    = '0;
            end else if (tick_wrap) begin
               state_n = DATA;
               idx_n   = '0;
            end
         end
         DATA: begin
            // LSB arrives first, so shifting right leaves bit idx at position idx
            if (decide)
               shift_n = {maj, shift[DATA_BITS-1:1]};
            if (tick_wrap) begin
               if (idx == IDX_LAST)
                  state_n = PAR_ON ? PARITY : STOP;
               else
                  idx_n = idx + 1'b1;
            end
         end
         PARITY: begin
            if (decide && (maj != ((^shift) ^ PAR_INV)))
               perr_n = 1'b1;
            if (tick_wrap) begin
               state_n = STOP;
               sidx_n  = 1'b0;
            end
         end
         STOP: begin
            // Leaving at the last decision gives half a bit of margin for the next start edge
            if (decide) begin
               if (!maj)
                  ferr_n = 1'b1;
               if (sidx == SIDX_LAST) begin
                  state_n = IDLE;
                  tc_n    = '0;
                  done    = 1'b1;
               end
            end else if (tick_wrap) begin
               sidx_n = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            tc_n    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         tc         <= '0;
         idx        <= '0;
         sidx       <= 1'b0;
         shift      <= '0;
         perr       <= 1'b0;
         ferr       <= 1'b0;
         s_lo       <= 1'b1;
         s_mid      <= 1'b1;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         tc         <= tc_n;
         idx        <= idx_n;
         sidx       <= sidx_n;
         shift      <= shift_n;
         perr       <= perr_n;
         ferr       <= ferr_n;
         data_valid <= done;
         if (baud_tick && tc == TC_LO)
            s_lo <= rxs;
         if (baud_tick && tc == TC_MID)
            s_mid <= rxs;
         if (done) begin
            data_out   <= shift;
            parity_err <= PAR_ON & perr;
            frame_err  <= ferr_n;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: three configurations (8N1, 8E1, 7N2) share
// one clock, reset and baud tick; each has its own rx line and pulse monitor.
module tb_uart_rx_word;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic baud_tick = 1'b0;
   logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
   logic [7:0] dout_a, dout_b;
   logic [6:0] dout_c;
   logic dv_a, dv_b, dv_c, perr_a, perr_b, perr_c;
   logic ferr_a, ferr_b, ferr_c, busy_a, busy_b, busy_c;

   int tests = 0;
   int failed = 0;
   int tick_cnt = 0;
   int vcount[3];
   int vtick[3];
   int start_tick[3];
   logic [1:0] ph = 2'd0;

   uart_rx_word #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_a), .data_out(dout_a),
      .data_valid(dv_a), .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a));

   uart_rx_word #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_b), .data_out(dout_b),
      .data_valid(dv_b), .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b));

   uart_rx_word #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_c (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_c), .data_out(dout_c),
      .data_valid(dv_c), .parity_err(perr_c), .frame_err(ferr_c), .busy(busy_c));

   always #5 clk = ~clk;

   // One baud tick every fourth clock, changed on the falling edge
   always @(negedge clk) begin
      ph = ph + 2'd1;
      baud_tick = (ph == 2'd0);
   end

   always @(posedge clk) if (baud_tick) tick_cnt <= tick_cnt + 1;

   always @(negedge clk) begin
      if (dv_a) begin vcount[0]++; vtick[0] = tick_cnt; end
      if (dv_b) begin vcount[1]++; vtick[1] = tick_cnt; end
      if (dv_c) begin vcount[2]++; vtick[2] = tick_cnt; end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic waitTicks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!baud_tick) @(posedge clk);
      end
      @(negedge clk);
   endtask

   task automatic setRx(input int sel, input logic v);
      case (sel)
         0: rx_a = v;
         1: rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   // glitch drives the opposite level for the single tick at tc = M
   task automatic sendBit(input int sel, input logic v, input bit glitch);
      setRx(sel, v);
      if (glitch) begin
         waitTicks(8);
         setRx(sel, ~v);
         waitTicks(1);
         setRx(sel, v);
         waitTicks(7);
      end else begin
         waitTicks(16);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic [8:0] data, input int nbits,
                                input bit par_en, input logic par_bit, input int nstop,
                                input logic stop_val, input int glitch_bit);
      start_tick[sel] = tick_cnt;
      sendBit(sel, 1'b0, 1'b0);
      for (int i = 0; i < nbits; i++)
         sendBit(sel, data[i], (i == glitch_bit));
      if (par_en)
         sendBit(sel, par_bit, 1'b0);
      for (int i = 0; i < nstop; i++)
         sendBit(sel, stop_val, 1'b0);
   endtask

   initial begin
      waitTicks(2);
      rst = 1'b0;
      waitTicks(2);
      checkOutput("reset data_out", 32'(dout_a), 32'h0);
      checkOutput("reset data_valid", 32'(dv_a), 32'h0);
      checkOutput("reset parity_err", 32'(perr_a), 32'h0);
      checkOutput("reset frame_err", 32'(ferr_a), 32'h0);
      checkOutput("reset busy", 32'(busy_a), 32'h0);
      checkOutput("reset busy 7N2", 32'(busy_c), 32'h0);

      // 8N1 0xA5: single pulse, clean flags, latency (F-1)*16 + 8 + 2 = 154 ticks
      applyStimulus(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, -1);
      waitTicks(4);
      checkOutput("A5 count", 32'(vcount[0]), 32'd1);
      checkOutput("A5 data", 32'(dout_a), 32'hA5);
      checkOutput("A5 parity_err", 32'(perr_a), 32'h0);
      checkOutput("A5 frame_err", 32'(ferr_a), 32'h0);
      checkOutput("A5 busy after", 32'(busy_a), 32'h0);
      checkOutput("A5 latency", 32'(vtick[0] - start_tick[0]), 32'd154);

      // False start: low for 5 ticks, rejected at the 10th tick of START
      setRx(0, 1'b0);
      waitTicks(2);
      checkOutput("glitch busy high", 32'(busy_a), 32'h1);
      waitTicks(3);
      setRx(0, 1'b1);
      waitTicks(5);
      checkOutput("glitch busy low", 32'(busy_a), 32'h0);
      waitTicks(10);
      checkOutput("glitch count", 32'(vcount[0]), 32'd1);
      checkOutput("glitch data kept", 32'(dout_a), 32'hA5);
      checkOutput("glitch frame_err kept", 32'(ferr_a), 32'h0);

      // 8E1: 0x3C has four ones, so even parity bit is 0; 0x07 needs 1
      applyStimulus(1, 9'h03C, 8, 1'b1, 1'b1, 1, 1'b1, -1);
      waitTicks(4);
      checkOutput("3C/p1 count", 32'(vcount[1]), 32'd1);
      checkOutput("3C/p1 data", 32'(dout_b), 32'h3C);
      checkOutput("3C/p1 parity_err", 32'(perr_b), 32'h1);
      checkOutput("3C/p1 frame_err", 32'(ferr_b), 32'h0);
      applyStimulus(1, 9'h03C, 8, 1'b1, 1'b0, 1, 1'b1, -1);
      waitTicks(4);
      checkOutput("3C/p0 count", 32'(vcount[1]), 32'd2);
      checkOutput("3C/p0 parity_err", 32'(perr_b), 32'h0);
      applyStimulus(1, 9'h007, 8, 1'b1, 1'b1, 1, 1'b1, -1);
      waitTicks(4);
      checkOutput("07/p1 data", 32'(dout_b), 32'h07);
      checkOutput("07/p1 parity_err", 32'(perr_b), 32'h0);

      // 7N2 back-to-back, glitch on data bit 3 of the second frame
      applyStimulus(2, 9'h041, 7, 1'b0, 1'b0, 2, 1'b1, -1);
      checkOutput("41 count", 32'(vcount[2]), 32'd1);
      checkOutput("41 data", 32'(dout_c), 32'h41);
      checkOutput("41 latency", 32'(vtick[2] - start_tick[2]), 32'd154);
      applyStimulus(2, 9'h07F, 7, 1'b0, 1'b0, 2, 1'b1, 3);
      waitTicks(4);
      checkOutput("7F count", 32'(vcount[2]), 32'd2);
      checkOutput("7F data", 32'(dout_c), 32'h7F);
      checkOutput("7F frame_err", 32'(ferr_c), 32'h0);
      checkOutput("7F parity_err", 32'(perr_c), 32'h0);

      // 0x55 with a 0 stop bit, then the line stays low for three frame times
      applyStimulus(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b0, -1);
      checkOutput("55 count", 32'(vcount[0]), 32'd2);
      checkOutput("55 data", 32'(dout_a), 32'h55);
      checkOutput("55 frame_err", 32'(ferr_a), 32'h1);
      waitTicks(480);
      checkOutput("break count", 32'(vcount[0]), 32'd2);
      checkOutput("break busy", 32'(busy_a), 32'h0);
      setRx(0, 1'b1);
      waitTicks(16);
      applyStimulus(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1, -1);
      waitTicks(4);
      checkOutput("C3 count", 32'(vcount[0]), 32'd3);
      checkOutput("C3 data", 32'(dout_a), 32'hC3);
      checkOutput("C3 frame_err", 32'(ferr_a), 32'h0);

      // Reset during data bit 4 of 0xFF, then a clean 0x12
      sendBit(0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) sendBit(0, 1'b1, 1'b0);
      waitTicks(5);
      checkOutput("midframe busy", 32'(busy_a), 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("rst data_out", 32'(dout_a), 32'h0);
      checkOutput("rst busy", 32'(busy_a), 32'h0);
      checkOutput("rst frame_err", 32'(ferr_a), 32'h0);
      waitTicks(3);
      rst = 1'b0;
      waitTicks(160);
      checkOutput("post-rst count", 32'(vcount[0]), 32'd3);
      checkOutput("post-rst data_out", 32'(dout_a), 32'h0);
      checkOutput("post-rst busy", 32'(busy_a), 32'h0);
      applyStimulus(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b1, -1);
      waitTicks(4);
      checkOutput("12 count", 32'(vcount[0]), 32'd4);
      checkOutput("12 data", 32'(dout_a), 32'h12);
      checkOutput("12 frame_err", 32'(ferr_a), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
